// File: rtl/joypad_pkg.sv
// Shared types, idle value and valid-code tables for the joypad P1 front-end.
package joypad_pkg;

  localparam int JOY_W = 6;

  typedef logic [JOY_W-1:0] joy_vec_t;

  localparam joy_vec_t JOY_IDLE = 6'h3F;

  // Group selects are bits [5:4]; key lines are bits [3:0]. All active-low.
  localparam logic [7:0][JOY_W-1:0] FULL_CODES = {
    6'b101110, 6'b101101, 6'b101011, 6'b100111,
    6'b011110, 6'b011101, 6'b011011, 6'b010111
  };
  localparam logic [1:0][JOY_W-1:0] SEL_CODES = {6'b011111, 6'b101111};
  localparam logic [3:0][JOY_W-1:0] KEY_CODES = {
    6'b111110, 6'b111101, 6'b111011, 6'b110111
  };

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_FULL = 2'd1,
    CLS_SEL  = 2'd2,
    CLS_KEY  = 2'd3
  } joy_cls_e;

  function automatic joy_cls_e code_class(input joy_vec_t v);
    joy_cls_e cls;
    cls = CLS_NONE;
    for (int i = 0; i < 8; i++) if (v == FULL_CODES[i]) cls = CLS_FULL;
    for (int i = 0; i < 2; i++) if (v == SEL_CODES[i]) cls = CLS_SEL;
    for (int i = 0; i < 4; i++) if (v == KEY_CODES[i]) cls = CLS_KEY;
    return cls;
  endfunction

endpackage

// File: rtl/joypad_hist_reg.sv
// Free-running history register with asynchronous active-low reset to RST_VAL.
module joypad_hist_reg #(
  parameter int             W       = 6,
  parameter logic [W-1:0]   RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= RST_VAL;
    else        q <= d;
  end

endmodule

// File: rtl/joypad_io_ctrl.sv
// Joypad P1/JOYP resolver: merges single/dual presses against input/output history.
// Build option JOYPAD_TOGGLE_EN: every valid code drives the merged code straight out.
module joypad_io_ctrl
  import joypad_pkg::*;
#(
  parameter int             P_W      = 6,
  parameter logic [P_W-1:0] IDLE_VAL = 6'b111111
) (
  input  logic           Clock,
  input  logic           Reset,
  input  logic [P_W-1:0] iP,
  output logic [P_W-1:0] oP,
  output logic           oIE
);

  joy_vec_t ip_last, op_last;
  joy_vec_t xa, ma, mb, op_res;

  joypad_hist_reg #(.W(P_W), .RST_VAL(IDLE_VAL)) u_ip_hist (
    .clk(Clock), .rst_n(Reset), .d(iP), .q(ip_last)
  );

  joypad_hist_reg #(.W(P_W), .RST_VAL(IDLE_VAL)) u_op_hist (
    .clk(Clock), .rst_n(Reset), .d(oP), .q(op_last)
  );

  // xa marks lines that still agree with what was last reported.
  assign xa = ~(iP ^ op_last);
  assign ma = (&iP) ? iP : xa;
  assign mb = (&xa) ? iP : ma;

`ifdef JOYPAD_TOGGLE_EN
  always_comb begin
    op_res = JOY_IDLE;
    if (code_class(mb) != CLS_NONE) op_res = mb;
  end
`else
  joy_vec_t xb;
  logic     changed;

  assign xb      = ~(iP ^ ip_last);
  assign changed = ~(&xb);

  // Without an input edge the last reported value is held.
  always_comb begin
    op_res = JOY_IDLE;
    case (code_class(mb))
      CLS_FULL: op_res = changed ? mb : op_last;
      CLS_SEL:  op_res = changed ? {mb[5:4], op_last[3:0]} : op_last;
      CLS_KEY:  op_res = changed ? {op_last[5:4], mb[3:0]} : op_last;
      default:  op_res = JOY_IDLE;
    endcase
  end
`endif

  assign oP  = Reset ? op_res : JOY_IDLE;
  assign oIE = ~(&oP);

endmodule

// File: tb/tb_joypad_io_ctrl.sv
// Directed plus randomized bench for joypad_io_ctrl against a behavioural model.
module tb_joypad_io_ctrl;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic [5:0] iP    = 6'h3F;
  logic [5:0] oP;
  logic       oIE;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] m_ipl = 6'h3F;
  logic [5:0] m_opl = 6'h3F;

  joypad_io_ctrl dut (
    .Clock(Clock), .Reset(Reset), .iP(iP), .oP(oP), .oIE(oIE)
  );

  always #5 Clock = ~Clock;

  // Model: lines agreeing with the last output form the candidate code; an
  // all-released input or a fully agreeing input passes the raw input instead.
  function automatic logic [5:0] ref_out(input logic [5:0] ip, input logic [5:0] ipl,
                                         input logic [5:0] opl);
    logic [5:0] agree, pick;
    bit         chg;
    for (int i = 0; i < 6; i++) agree[i] = (ip[i] == opl[i]);
    pick = (ip == 6'h3F || agree == 6'h3F) ? ip : agree;
    chg  = (ip != ipl);
`ifdef JOYPAD_TOGGLE_EN
    chg  = 1'b1;
`endif
    if (pick inside {6'b101110, 6'b101101, 6'b101011, 6'b100111,
                     6'b011110, 6'b011101, 6'b011011, 6'b010111})
      return chg ? pick : opl;
    if (pick inside {6'b011111, 6'b101111}) begin
`ifdef JOYPAD_TOGGLE_EN
      return pick;
`else
      return chg ? {pick[5:4], opl[3:0]} : opl;
`endif
    end
    if (pick inside {6'b111110, 6'b111101, 6'b111011, 6'b110111}) begin
`ifdef JOYPAD_TOGGLE_EN
      return pick;
`else
      return chg ? {opl[5:4], pick[3:0]} : opl;
`endif
    end
    return 6'h3F;
  endfunction

  task automatic chk(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive v one step after a rising edge, check mid-cycle, then clock it in.
  task automatic apply(input logic [5:0] v, output logic [5:0] exp);
    iP = v;
    #1;
    exp = ref_out(v, m_ipl, m_opl);
    chk("oP", oP, exp);
    chk("oIE", {5'b0, oIE}, {5'b0, exp != 6'h3F});
    @(posedge Clock);
    m_ipl = v;
    m_opl = exp;
    #1;
  endtask

  // Asynchronous reset pulse entirely between clock edges, with v held.
  task automatic reset_pulse(input logic [5:0] v);
    logic [5:0] exp;
    iP    = v;
    Reset = 1'b0;
    #1;
    m_ipl = 6'h3F;
    m_opl = 6'h3F;
    chk("rst_oP", oP, 6'h3F);
    chk("rst_oIE", {5'b0, oIE}, 6'h00);
    #4;
    Reset = 1'b1;
    #1;
    exp = ref_out(v, m_ipl, m_opl);
    chk("rel_oP", oP, exp);
    chk("rel_oIE", {5'b0, oIE}, {5'b0, exp != 6'h3F});
    @(posedge Clock);
    m_ipl = v;
    m_opl = exp;
    #1;
  endtask

  logic [5:0] e;
  logic [5:0] codes [14] = '{6'b101110, 6'b101101, 6'b101011, 6'b100111,
                             6'b011110, 6'b011101, 6'b011011, 6'b010111,
                             6'b011111, 6'b101111,
                             6'b111110, 6'b111101, 6'b111011, 6'b110111};

  initial begin
    #12;
    chk("reset_oP", oP, 6'h3F);
    chk("reset_oIE", {5'b0, oIE}, 6'h00);
    #1;
    Reset = 1'b1;
    #1;
    chk("release_oP", oP, 6'h3F);
    chk("release_oIE", {5'b0, oIE}, 6'h00);
    @(posedge Clock);
    #1;

    // Single press, held, then released.
    apply(6'b101110, e);
    chk("press_lit", oP, 6'b101110);
    for (int i = 0; i < 3; i++) begin
      apply(6'b101110, e);
      chk("hold_lit", oP, 6'b101110);
    end
    apply(6'b111111, e);
    chk("rel_lit", oP, 6'b111111);
    chk("rel_ie_lit", {5'b0, oIE}, 6'h00);

    // Key press then second group select: merged result.
    apply(6'b111110, e);
    chk("key_lit", oP, 6'b111110);
    apply(6'b011110, e);
`ifdef JOYPAD_TOGGLE_EN
    chk("merge_lit", oP, 6'b011111);
`else
    chk("merge_lit", oP, 6'b011110);
`endif
    chk("merge_ie_lit", {5'b0, oIE}, 6'h01);
    apply(6'b111111, e);

    // Both group selects low falls to the idle value.
    apply(6'b001110, e);
    chk("bothsel_lit", oP, 6'h3F);
    chk("bothsel_ie_lit", {5'b0, oIE}, 6'h00);
    apply(6'b111111, e);

    // Reset asserted mid-press, released with the press still held.
    apply(6'b011101, e);
    apply(6'b011101, e);
    reset_pulse(6'b011101);
    chk("rst_rel_lit", oP, 6'b011101);
    apply(6'b011101, e);

    for (int n = 0; n < 400; n++) begin
      int unsigned r;
      logic [5:0]  v;
      r = $urandom_range(0, 99);
      if (r < 50)      v = codes[$urandom_range(0, 13)];
      else if (r < 70) v = iP;
      else if (r < 80) v = 6'h3F;
      else             v = 6'($urandom);
      if ($urandom_range(0, 39) == 0) reset_pulse(v);
      else                            apply(v, e);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
